i2s_rx: RTL and testbench
=========================

# i2s_rx

I2S receive-side deserializer for the ADAU1761 audio path. It captures `ac_adc_sdata` using the BCLK/LRCLK pair already driven by the transmitter in the `clk_12` domain. It presents complete left/right 24-bit sample pairs on a valid/ready interface toward the DSP/`top` logic. It is the capture counterpart of the existing I2S transmit path, which is currently built with `EN_RX_I` tied low.

## Interface
- `DATA_W`, 24: captured sample width (MSB-first, left-justified in slot).
- `SLOT_W`, 32: BCLK periods per channel slot; bits beyond `DATA_W` ignored.
- `clk` in 1: system clock (`clk_12`, 12.288 MHz); every register is on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `bclk_i` in 1: bit clock from the I2S transmitter.
- `lrclk_i` in 1: word select; 0 = left, 1 = right.
- `sdata_i` in 1: serial ADC data; changes on BCLK falling edge.
- `d_l_o` out `DATA_W`: left sample of delivered frame.
- `d_r_o` out `DATA_W`: right sample of delivered frame.
- `valid_o` out 1: frame pair available.
- `ready_i` in 1: consumer accepts; a transfer occurs when `valid_o & ready_i`.
- `sync_o` out 1: receiver is locked to the frame.
- `overrun_o` out 1: sticky; a frame was dropped because the output was still held.

## Operation
- Inputs: `bclk_i`, `lrclk_i`, `sdata_i` each pass through an identical 2-flop synchronizer (aligned latency).
- BCLK rise detect: synced BCLK = 1 and its previous value = 0. All capture happens only on detected rises.
- Required BCLK high and low times: ≥ 2 `clk` each. The nominal rate is `clk`/4.
- On each rise, sample synced LRCLK (`lr`) and SDATA, then compare `lr` with `lr_prev`.
- I2S 1-bit delay: a rise where `lr != lr_prev` carries the LSB slot of the previous word. It resets `bit_cnt` to 0 and sets `chan = lr`. The next rise is the MSB.
- On other rises with `bit_cnt < DATA_W`: shift SDATA into `shreg` and increment `bit_cnt`.
  - On the `DATA_W`-th bit, copy the word to the `hold_l` or `hold_r` register per `chan`, and mark that channel done.
- Bits `DATA_W`..`SLOT_W-1` are ignored and `bit_cnt` saturates.
- FSM states:
  - UNSYNC: ignore data. On an `lr` 1→0 transition, go to RUN and clear the done flags.
  - RUN: capture as above.
  - Frame complete: right word finished while left done flag is set. This updates the outputs (see handshake) and clears the done flags.
- Short slot: an LR transition with `bit_cnt < DATA_W` in RUN drops the partial word. It clears both done flags, so that frame is not delivered, and the FSM stays in RUN.
- A right word completed without a left word in the same frame is discarded.
- Handshake:
  - Frame complete with `valid_o` = 0, or with `valid_o & ready_i` in the same cycle: load `d_l_o`/`d_r_o` and hold `valid_o` = 1.
  - Frame complete with `valid_o & !ready_i`: drop the new frame, set `overrun_o`, and keep the old data.
  - `valid_o & ready_i` with no completion: `valid_o` goes to 0 next cycle.
- `d_*_o` are stable while `valid_o` = 1.
- `sync_o` = 1 exactly while in RUN.

## Timing
- Reset values: all outputs 0 (`d_l_o`, `d_r_o`, `valid_o`, `sync_o`, `overrun_o`), FSM in UNSYNC, `bit_cnt` 0, done flags 0, `lr_prev` 0.
- `rst` mid-frame aborts capture. `overrun_o` clears only on `rst`.
- Capture latency: pin edge sampled at clk edge N, and the detected rise acts at edge N+2.
- `valid_o` rises at edge N+2 relative to the BCLK rise carrying the right word's bit `DATA_W`-1 (its LSB).
- First delivered frame: the first complete frame after the first observed left-slot start following reset.
- Throughput: one frame per LRCLK period; 48 kHz nominal.

## Structure
- Shared package `i2s_pkg`: `DATA_W`/`SLOT_W` defaults, `i2s_rx_state_t` enum {UNSYNC, RUN}, and channel constants `CH_L`=0, `CH_R`=1. The transmitter should adopt the same package.
- Sub-module `i2s_sync_edge`: 2-flop synchronizer with optional rise/fall pulse outputs. It is instantiated for BCLK and LRCLK; SDATA uses the sync output only.

## Test plan
- Locked capture: BCLK = `clk`/4, stream left 24'hA5C3F1 and right 24'h123456 in 32-bit slots. Expect `sync_o`=1, then `valid_o`=1 with `d_l_o`=A5C3F1 and `d_r_o`=123456 on every frame; `ready_i` held 1.
- Start mid-right-slot after reset: the first partial frame is not delivered, and the first `valid_o` carries the next full L/R pair.
- Backpressure: `ready_i`=0 for 2 frames. Expect the first pair held, `overrun_o`=1, and data unchanged. Then `ready_i`=1 delivers that first pair.
- Simultaneous: `ready_i` pulses in the completion cycle. Expect the new pair loaded, `valid_o` stays 1, `overrun_o` stays 0.
- Short slot: LRCLK toggles after 16 bits of left. Expect that frame dropped, the next full frame delivered correctly, and `sync_o` stays 1.
- `rst` asserted mid-left-word: outputs go to 0 the next cycle and `sync_o`=0. Recovery happens on the next LRCLK falling edge.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the ADAU1761 audio path (receive and transmit).
// Contents: default word/slot widths, receiver FSM state type, channel codes
// matching the LRCLK level (0 = left, 1 = right).
package i2s_pkg;

    localparam int I2S_DATA_W = 24;
    localparam int I2S_SLOT_W = 32;

    typedef enum logic {
        UNSYNC = 1'b0,
        RUN    = 1'b1
    } i2s_rx_state_t;

    localparam logic CH_L = 1'b0;
    localparam logic CH_R = 1'b1;

endpackage

// File: rtl/i2s_sync_edge.sv
// Two-flop synchronizer with rise/fall pulse outputs taken from the
// synchronized level and its one-cycle-delayed copy.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   din      : asynchronous input
//   sync     : synchronized level (2-flop latency)
//   rise     : one-cycle pulse, sync went 0->1
//   fall     : one-cycle pulse, sync went 1->0
module i2s_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [2:0] q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 3'b000;
        end else begin
            q <= {q[1:0], din};
        end
    end

    assign sync = q[1];
    assign rise = q[1] & ~q[2];
    assign fall = ~q[1] & q[2];

endmodule

// File: rtl/i2s_rx.sv
// I2S receive deserializer: captures sdata_i on BCLK rises (detected in the
// clk domain) and presents complete left/right sample pairs on valid/ready.
// Ports:
//   clk, rst           : system clock, synchronous active-high reset
//   bclk_i, lrclk_i    : bit clock and word select from the transmitter
//   sdata_i            : serial ADC data, MSB first, one BCLK after LRCLK edge
//   d_l_o, d_r_o       : delivered left/right samples, stable while valid_o
//   valid_o, ready_i   : frame handshake, transfer on valid_o & ready_i
//   sync_o             : receiver is locked to the frame
//   overrun_o          : sticky, a complete frame was dropped (output held)
//
// state  | meaning
// UNSYNC | waiting for an LRCLK 1->0 (left slot start); data ignored
// RUN    | locked; capturing words and delivering L/R pairs
import i2s_pkg::*;

module i2s_rx #(
    parameter int DATA_W = I2S_DATA_W,
    parameter int SLOT_W = I2S_SLOT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bclk_i,
    input  logic              lrclk_i,
    input  logic              sdata_i,
    output logic [DATA_W-1:0] d_l_o,
    output logic [DATA_W-1:0] d_r_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              sync_o,
    output logic              overrun_o
);

    localparam int CNT_W = $clog2(SLOT_W + 1);

    logic bclk_s, bclk_rise, unused_bclk_fall;
    logic lr_s, unused_lr_rise, unused_lr_fall;
    logic sd_s, unused_sd_rise, unused_sd_fall;

    i2s_sync_edge u_sync_bclk (.clk(clk), .rst(rst), .din(bclk_i),
                               .sync(bclk_s), .rise(bclk_rise), .fall(unused_bclk_fall));
    i2s_sync_edge u_sync_lr   (.clk(clk), .rst(rst), .din(lrclk_i),
                               .sync(lr_s), .rise(unused_lr_rise), .fall(unused_lr_fall));
    i2s_sync_edge u_sync_sd   (.clk(clk), .rst(rst), .din(sdata_i),
                               .sync(sd_s), .rise(unused_sd_rise), .fall(unused_sd_fall));

    i2s_rx_state_t     state, state_next;
    logic              lr_prev;
    logic              chan;
    logic              done_l;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-2:0] shreg;
    logic [DATA_W-1:0] hold_l;

    logic              lr_edge, data_bit, word_last, frame_done;
    logic [DATA_W-1:0] word;

    // The rise where LRCLK has changed carries the previous word's last slot
    // bit, so it only realigns the counter; data starts on the next rise.
    assign lr_edge    = bclk_rise && (lr_s != lr_prev);
    assign data_bit   = bclk_rise && (state == RUN) && !lr_edge && (bit_cnt < CNT_W'(SLOT_W));
    assign word_last  = data_bit && (bit_cnt == CNT_W'(DATA_W - 1));
    assign word       = {shreg, sd_s};
    assign frame_done = word_last && (chan == CH_R) && done_l;
    assign sync_o     = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= UNSYNC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            UNSYNC:  if (bclk_rise && lr_prev && !lr_s) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = UNSYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lr_prev   <= 1'b0;
            chan      <= CH_L;
            done_l    <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            hold_l    <= '0;
            d_l_o     <= '0;
            d_r_o     <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            if (bclk_rise) lr_prev <= lr_s;

            if (state == UNSYNC) begin
                if (state_next == RUN) begin
                    bit_cnt <= '0;
                    chan    <= CH_L;
                    done_l  <= 1'b0;
                end
            end else if (lr_edge) begin
                // A slot ending before a full word drops the whole frame.
                if (bit_cnt < CNT_W'(DATA_W)) done_l <= 1'b0;
                bit_cnt <= '0;
                chan    <= lr_s;
            end else if (data_bit) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (bit_cnt < CNT_W'(DATA_W)) shreg <= word[DATA_W-2:0];
                if (word_last) begin
                    if (chan == CH_L) begin
                        hold_l <= word;
                        done_l <= 1'b1;
                    end else begin
                        // Right word ends the frame whether or not it is kept.
                        done_l <= 1'b0;
                    end
                end
            end

            if (frame_done) begin
                if (!valid_o || ready_i) begin
                    d_l_o   <= hold_l;
                    d_r_o   <= word;
                    valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
module tb_i2s_rx;

    localparam int DW = 24;
    localparam int SW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          bclk_i, lrclk_i, sdata_i, ready_i;
    logic [DW-1:0] d_l_o, d_r_o;
    logic          valid_o, sync_o, overrun_o;

    i2s_rx #(.DATA_W(DW), .SLOT_W(SW)) dut (
        .clk(clk), .rst(rst), .bclk_i(bclk_i), .lrclk_i(lrclk_i), .sdata_i(sdata_i),
        .d_l_o(d_l_o), .d_r_o(d_r_o), .valid_o(valid_o), .ready_i(ready_i),
        .sync_o(sync_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [2*DW-1:0] exp_q[$];

    // slot-level reference model
    bit          m_locked, m_prev_lr, m_left_ok, m_held, m_ready_phase, m_overrun;
    logic [DW-1:0] m_left;

    bit pulse_next, lat_pending;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_prev_lr = 0; m_left_ok = 0; m_held = 0; m_overrun = 0;
    endtask

    task automatic deliver(input logic [2*DW-1:0] pair, input bit pulse);
        if (m_held && !pulse) begin
            m_overrun = 1;
        end else begin
            exp_q.push_back(pair);
            m_held = !m_ready_phase;
        end
    endtask

    // Decide at slot start what this slot contributes to the delivered stream.
    task automatic model_slot(input logic ch, input logic [DW-1:0] w, input int nrises, input bit pulse);
        bit full;
        full = (nrises > DW);
        if (!m_locked && ch == 1'b0 && m_prev_lr) begin
            m_locked  = 1;
            m_left_ok = 0;
        end
        if (m_locked) begin
            if (ch == 1'b0) begin
                m_left_ok = full;
                m_left    = w;
            end else begin
                if (full && m_left_ok) deliver({m_left, w}, pulse);
                m_left_ok = 0;
            end
        end
        m_prev_lr = ch;
    endtask

    task automatic set_ready(input logic v);
        @(negedge clk);
        ready_i       = v;
        m_ready_phase = v;
        if (v) m_held = 0;
    endtask

    task automatic bit_cycle(input logic lr, input logic d);
        @(negedge clk);
        bclk_i = 1'b0; lrclk_i = lr; sdata_i = d;
        if (pulse_next) ready_i = 1'b1;
        if (lat_pending) begin #1; chk("latency_before", valid_o, 0); end
        @(negedge clk);
        if (pulse_next) begin ready_i = 1'b0; pulse_next = 0; end
        if (lat_pending) begin #1; chk("latency_at", valid_o, 1); lat_pending = 0; end
        @(negedge clk);
        bclk_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_slot(input logic ch, input logic [DW-1:0] w, input int nrises,
                             input bit pulse, input bit lat);
        logic d;
        model_slot(ch, w, nrises, pulse);
        for (int k = 0; k < nrises; k++) begin
            if (k >= 1 && k <= DW) d = w[DW-k];
            else                   d = 1'($urandom_range(0, 1));
            bit_cycle(ch, d);
            if (k == DW && ch == 1'b1) begin
                pulse_next  = pulse;
                lat_pending = lat;
            end
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                              input bit pulse, input bit lat);
        send_slot(1'b0, l, SW, 0, 0);
        send_slot(1'b1, r, SW, pulse, lat);
    endtask

    // scoreboard monitor
    logic          prev_valid, prev_xfer;
    logic [2*DW-1:0] prev_d;
    initial begin
        logic [2*DW-1:0] p;
        prev_valid = 0; prev_xfer = 0; prev_d = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (prev_valid && !prev_xfer) chk("data_stable", {d_l_o, d_r_o}, prev_d);
                if (valid_o && ready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_pair actual=%0h required=none", {d_l_o, d_r_o});
                    end else begin
                        p = exp_q.pop_front();
                        chk("pair_left", d_l_o, p[2*DW-1:DW]);
                        chk("pair_right", d_r_o, p[DW-1:0]);
                    end
                end
                prev_valid = valid_o;
                prev_xfer  = valid_o && ready_i;
                prev_d     = {d_l_o, d_r_o};
            end else begin
                prev_valid = 0;
                prev_xfer  = 0;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] al, ar, bl, br, cl, cr;
        rst = 1'b1; bclk_i = 0; lrclk_i = 0; sdata_i = 0; ready_i = 1'b1;
        pulse_next = 0; lat_pending = 0; m_ready_phase = 1;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("reset_d_l", d_l_o, 0);
        chk("reset_d_r", d_r_o, 0);
        chk("reset_valid", valid_o, 0);
        chk("reset_sync", sync_o, 0);
        chk("reset_overrun", overrun_o, 0);
        @(negedge clk); rst = 1'b0;

        // start mid-right-slot, then locked capture
        send_slot(1'b1, DW'($urandom), 12, 0, 0);
        chk("unsync_before_left", sync_o, 0);
        send_frame(24'hA5C3F1, 24'h123456, 0, 1);
        chk("sync_locked", sync_o, 1);
        send_frame(24'hA5C3F1, 24'h123456, 0, 1);
        send_frame(24'hA5C3F1, 24'h123456, 0, 0);
        for (int i = 0; i < 4; i++) send_frame(DW'($urandom), DW'($urandom), 0, i == 2);

        // ready pulse coincident with completion
        set_ready(0);
        al = DW'($urandom); ar = DW'($urandom); bl = DW'($urandom); br = DW'($urandom);
        send_frame(al, ar, 0, 0);
        send_frame(bl, br, 1, 0);
        #1;
        chk("simul_valid", valid_o, 1);
        chk("simul_overrun", overrun_o, m_overrun);
        chk("simul_d_l", d_l_o, bl);
        chk("simul_d_r", d_r_o, br);
        set_ready(1);
        repeat (2) @(negedge clk);

        // backpressure across two further frames
        set_ready(0);
        cl = DW'($urandom); cr = DW'($urandom);
        send_frame(cl, cr, 0, 0);
        send_frame(DW'($urandom), DW'($urandom), 0, 0);
        send_frame(DW'($urandom), DW'($urandom), 0, 0);
        #1;
        chk("bp_overrun", overrun_o, m_overrun);
        chk("bp_valid", valid_o, 1);
        chk("bp_d_l", d_l_o, cl);
        chk("bp_d_r", d_r_o, cr);
        set_ready(1);
        send_frame(DW'($urandom), DW'($urandom), 0, 0);

        // short left slot
        send_slot(1'b0, DW'($urandom), 17, 0, 0);
        send_slot(1'b1, DW'($urandom), SW, 0, 0);
        send_frame(DW'($urandom), DW'($urandom), 0, 1);
        chk("short_sync", sync_o, 1);

        // reset mid-left-word
        send_slot(1'b0, DW'($urandom), 10, 0, 0);
        chk("pre_reset_queue", exp_q.size(), 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        chk("rst_d_l", d_l_o, 0);
        chk("rst_d_r", d_r_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_sync", sync_o, 0);
        chk("rst_overrun", overrun_o, 0);
        @(negedge clk); rst = 1'b0;
        model_reset();
        exp_q.delete();
        send_slot(1'b0, DW'($urandom), 22, 0, 0);
        chk("rst_still_unsync", sync_o, 0);
        send_slot(1'b1, DW'($urandom), SW, 0, 0);
        send_frame(DW'($urandom), DW'($urandom), 0, 1);
        chk("recover_sync", sync_o, 1);
        send_frame(DW'($urandom), DW'($urandom), 0, 0);

        repeat (20) @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        chk("final_overrun", overrun_o, m_overrun);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
